// File: rtl/nx_fifo_ram_1r1w_ctrl.sv
//-----------------------------------------------------------------------------
// nx_fifo_ram_1r1w_ctrl
//
// Purpose:
//   Turns an external 1R1W RAM (active-low write/read enables, registered read
//   with a fixed latency) into a valid/ready streaming FIFO. The controller
//   owns the RAM write/read pointers and the RAM occupancy count. A small
//   prefetch skid buffer absorbs the RAM read latency so the read side
//   can stream one word per cycle.
//
//   Words in the FIFO are in exactly one of three places:
//     - the RAM (counted by r_ram_cnt),
//     - in flight from the RAM (one bit per word in r_inflight),
//     - the skid buffer (counted by r_skid_cnt).
//   'used' is the sum of all three.
//
// Parameters:
//   WIDTH      data word width
//   DEPTH      RAM entries (any value >= 2, not necessarily a power of 2)
//   RD_LATENCY RAM read latency in cycles (>= 1)
//   OUT_FLOP   1 when the RAM adds an output flop; total L = RD_LATENCY+OUT_FLOP
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_valid/ready    push handshake, wr_data is the pushed word
//   rd_valid/ready    pop handshake, rd_data is the head word
//   used              words accepted and not yet popped
//   ram_web/wa/din    RAM write port (web active-low), ram_bwe all-ones
//   ram_reb/ra        RAM read request (reb active-low)
//   ram_dout          RAM read data, valid L cycles after a ram_reb=0 cycle
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module nx_fifo_ram_1r1w_ctrl #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1,
    parameter int OUT_FLOP   = 0
) (
    input  logic                                              clk,
    input  logic                                              rst,

    input  logic                                              wr_valid,
    output logic                                              wr_ready,
    input  logic [WIDTH-1:0]                                  wr_data,

    output logic                                              rd_valid,
    input  logic                                              rd_ready,
    output logic [WIDTH-1:0]                                  rd_data,

    output logic [$clog2(DEPTH+RD_LATENCY+OUT_FLOP+3)-1:0]    used,

    output logic                                              ram_web,
    output logic [$clog2(DEPTH)-1:0]                          ram_wa,
    output logic [WIDTH-1:0]                                  ram_din,
    output logic [WIDTH-1:0]                                  ram_bwe,
    output logic                                              ram_reb,
    output logic [$clog2(DEPTH)-1:0]                          ram_ra,
    input  logic [WIDTH-1:0]                                  ram_dout
);

    //-------------------------------------------------------------------------
    // Derived sizes
    //-------------------------------------------------------------------------
    localparam int L  = RD_LATENCY + OUT_FLOP;   // total RAM read latency
    localparam int S  = L + 2;                   // skid buffer entries
    localparam int AW = $clog2(DEPTH);           // RAM address width
    localparam int CW = $clog2(DEPTH + 1);       // RAM occupancy width
    localparam int SW = $clog2(S);               // skid index width (S >= 3)
    localparam int KW = $clog2(S + 1);           // skid / inflight count width
    localparam int UW = $clog2(DEPTH + L + 3);   // 'used' width

    // Elaboration-time parameter sanity
    if (DEPTH < 2) begin : g_chk_depth
        $error("nx_fifo_ram_1r1w_ctrl: DEPTH must be at least 2");
    end
    if (RD_LATENCY < 1) begin : g_chk_lat
        $error("nx_fifo_ram_1r1w_ctrl: RD_LATENCY must be at least 1");
    end
    if ((OUT_FLOP != 0) && (OUT_FLOP != 1)) begin : g_chk_oflop
        $error("nx_fifo_ram_1r1w_ctrl: OUT_FLOP must be 0 or 1");
    end

    //-------------------------------------------------------------------------
    // Pointer helpers: wrap at DEPTH-1 / S-1, which need not be powers of 2
    //-------------------------------------------------------------------------
    function automatic logic [AW-1:0] ram_ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    function automatic logic [SW-1:0] skid_ptr_inc(input logic [SW-1:0] p);
        return (p == SW'(S - 1)) ? '0 : p + SW'(1);
    endfunction

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW-1:0]    r_ra;            // last issued read address
    logic [CW-1:0]    r_ram_cnt;
    logic [L-1:0]     r_inflight;      // bit k: read issued k+1 cycles ago
    logic [KW-1:0]    r_skid_cnt;
    logic [SW-1:0]    r_head;
    logic [SW-1:0]    r_tail;
    logic [WIDTH-1:0] r_skid_mem [S];
    logic [UW-1:0]    r_used;

    //-------------------------------------------------------------------------
    // Combinational control
    //-------------------------------------------------------------------------
    logic             w_wr_ready;
    logic             w_push;
    logic             w_issue;
    logic             w_capture;
    logic             w_rd_valid;
    logic             w_pop;
    logic [KW-1:0]    w_inflight_cnt;
    logic [L-1:0]     w_issue_vec;

    // Held low during reset so ram_web cannot pulse while rst is high.
    assign w_wr_ready = !rst && (r_ram_cnt < CW'(DEPTH));
    assign w_push     = wr_valid && w_wr_ready;

    // Number of reads currently travelling through the RAM pipeline.
    always_comb begin
        // NOTE: every always_comb target is given a default before any
        // conditional logic, so no path leaves it unassigned (no latch).
        w_inflight_cnt = '0;
        for (int i = 0; i < L; i++) begin
            w_inflight_cnt = w_inflight_cnt + KW'(r_inflight[i]);
        end
    end

    // Issue only when every word already committed (in flight or buffered)
    // plus this one still fits in the skid buffer. Uses registered counts, so
    // a pop this cycle grants credit only from the next cycle on. A word
    // pushed this cycle is not in r_ram_cnt yet, so the RAM never sees a
    // same-address write and read in one cycle.
    assign w_issue = (r_ram_cnt != '0) &&
                     ((int'(w_inflight_cnt) + int'(r_skid_cnt)) < S);

    // The oldest inflight bit marks the cycle ram_dout carries that word.
    assign w_capture = r_inflight[L-1];

    assign w_rd_valid = (r_skid_cnt != '0);
    assign w_pop      = w_rd_valid && rd_ready;

    always_comb begin
        w_issue_vec    = '0;
        w_issue_vec[0] = w_issue;
    end

    //-------------------------------------------------------------------------
    // Write pointer
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (w_push) begin
            // NOTE: sequential state uses nonblocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            r_wptr <= ram_ptr_inc(r_wptr);
        end
    end

    //-------------------------------------------------------------------------
    // Read pointer and held read address
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr <= '0;
            r_ra   <= '0;
        end else if (w_issue) begin
            r_rptr <= ram_ptr_inc(r_rptr);
            r_ra   <= r_rptr;
        end
    end

    //-------------------------------------------------------------------------
    // RAM occupancy: push adds, issue removes, both together cancel
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_cnt <= '0;
        end else begin
            case ({w_push, w_issue})
                2'b10:   r_ram_cnt <= r_ram_cnt + CW'(1);
                2'b01:   r_ram_cnt <= r_ram_cnt - CW'(1);
                default: r_ram_cnt <= r_ram_cnt;
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // Inflight shift register; clearing it on reset discards late returns
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= (r_inflight << 1) | w_issue_vec;
        end
    end

    //-------------------------------------------------------------------------
    // Skid buffer: circular, capture and pop may happen in the same cycle
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_skid_cnt <= '0;
        end else begin
            if (w_capture) begin
                r_tail <= skid_ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= skid_ptr_inc(r_head);
            end
            case ({w_capture, w_pop})
                2'b10:   r_skid_cnt <= r_skid_cnt + KW'(1);
                2'b01:   r_skid_cnt <= r_skid_cnt - KW'(1);
                default: r_skid_cnt <= r_skid_cnt;
            endcase
        end
    end

    // NOTE: the data storage has no reset; validity lives entirely in
    // r_skid_cnt, and leaving it unreset keeps it a plain register array.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_skid_mem[r_tail] <= ram_dout;
        end
    end

    //-------------------------------------------------------------------------
    // Total occupancy seen by the user
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_used <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_used <= r_used + UW'(1);
                2'b01:   r_used <= r_used - UW'(1);
                default: r_used <= r_used;
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // Outputs
    //-------------------------------------------------------------------------
    assign wr_ready = w_wr_ready;

    assign ram_web  = !w_push;
    assign ram_wa   = r_wptr;
    assign ram_din  = wr_data;
    assign ram_bwe  = '1;

    assign ram_reb  = !w_issue;
    assign ram_ra   = w_issue ? r_rptr : r_ra;

    assign rd_valid = w_rd_valid;
    assign rd_data  = r_skid_mem[r_head];
    assign used     = r_used;

    //-------------------------------------------------------------------------
    // Simulation-only invariants
    //-------------------------------------------------------------------------
    // The issue credit makes skid overflow impossible.
    a_skid_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_capture && !w_pop && (r_skid_cnt == KW'(S))));

    // The RAM never holds more than DEPTH words.
    a_ram_cnt_bound : assert property (@(posedge clk) disable iff (rst)
        (r_ram_cnt <= CW'(DEPTH)));

    // Every accepted word is in exactly one of RAM, flight or skid buffer.
    a_used_consistent : assert property (@(posedge clk) disable iff (rst)
        (int'(r_used) == int'(r_ram_cnt) + int'(w_inflight_cnt) + int'(r_skid_cnt)));

endmodule

// File: tb/tb_nx_fifo_ram_1r1w_ctrl.sv
//-----------------------------------------------------------------------------
// tb_nx_fifo_ram_1r1w_ctrl
//
// Two controller instances, each with a behavioural 1R1W RAM:
//   dut0: DEPTH=8, L=1 (RD_LATENCY=1, OUT_FLOP=0)
//   dut1: DEPTH=5, L=3 (RD_LATENCY=2, OUT_FLOP=1)
// A queue scoreboard per instance tracks accepted-not-popped words; each
// scenario task drives stimulus and makes its own comparisons.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nx_fifo_ram_1r1w_ctrl;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         wr_valid [2];
    logic         wr_ready [2];
    logic [W-1:0] wr_data  [2];
    logic         rd_valid [2];
    logic         rd_ready [2];
    logic [W-1:0] rd_data  [2];
    logic [3:0]   used     [2];
    logic         ram_web  [2];
    logic [2:0]   ram_wa   [2];
    logic [W-1:0] ram_din  [2];
    logic [W-1:0] ram_bwe  [2];
    logic         ram_reb  [2];
    logic [2:0]   ram_ra   [2];
    logic [W-1:0] ram_dout [2];

    int checks = 0;
    int errors = 0;

    nx_fifo_ram_1r1w_ctrl #(.WIDTH(W), .DEPTH(8), .RD_LATENCY(1), .OUT_FLOP(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_data(wr_data[0]),
        .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]), .rd_data(rd_data[0]),
        .used(used[0]),
        .ram_web(ram_web[0]), .ram_wa(ram_wa[0]), .ram_din(ram_din[0]), .ram_bwe(ram_bwe[0]),
        .ram_reb(ram_reb[0]), .ram_ra(ram_ra[0]), .ram_dout(ram_dout[0])
    );

    nx_fifo_ram_1r1w_ctrl #(.WIDTH(W), .DEPTH(5), .RD_LATENCY(2), .OUT_FLOP(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_data(wr_data[1]),
        .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]), .rd_data(rd_data[1]),
        .used(used[1]),
        .ram_web(ram_web[1]), .ram_wa(ram_wa[1]), .ram_din(ram_din[1]), .ram_bwe(ram_bwe[1]),
        .ram_reb(ram_reb[1]), .ram_ra(ram_ra[1]), .ram_dout(ram_dout[1])
    );

    //-------------------------------------------------------------------------
    // Behavioural RAMs: write at the edge, read data appears LAT cycles after
    // the ram_reb=0 cycle.
    //-------------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_ram
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [W-1:0] mem  [8];
        logic [W-1:0] pipe [LAT];
        always @(posedge clk) begin
            if (!ram_web[g]) mem[ram_wa[g]] <= ram_din[g];
            if (!ram_reb[g]) pipe[0] <= mem[ram_ra[g]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_dout[g] = pipe[LAT-1];
    end

    //-------------------------------------------------------------------------
    // Scoreboards: FIFO order and occupancy, sampled on the falling edge.
    //-------------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_sb
        logic [W-1:0] q [$];
        logic [W-1:0] exp_v;
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
            end else begin
                checks++;
                if (used[g] !== 4'(q.size())) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL sb%0d_used: got %0d expected %0d", g, used[g], q.size());
                end
                if (rd_valid[g] && rd_ready[g]) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        if (errors <= 20) $display("FAIL sb%0d_pop_empty: got pop expected none", g);
                    end else begin
                        exp_v = q.pop_front();
                        if (rd_data[g] !== exp_v) begin
                            errors++;
                            if (errors <= 20)
                                $display("FAIL sb%0d_data: got %h expected %h", g, rd_data[g], exp_v);
                        end
                    end
                end
                if (wr_valid[g] && wr_ready[g]) q.push_back(wr_data[g]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    //-------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wr_valid[k] = 1'b1;   // must be ignored while in reset
            wr_data[k]  = 16'hDEAD;
            rd_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd_valid[k] !== 1'b0) begin errors++; $display("FAIL rst%0d_rd_valid: got %b expected 0", k, rd_valid[k]); end
            checks++;
            if (ram_web[k] !== 1'b1) begin errors++; $display("FAIL rst%0d_ram_web: got %b expected 1", k, ram_web[k]); end
            checks++;
            if (ram_reb[k] !== 1'b1) begin errors++; $display("FAIL rst%0d_ram_reb: got %b expected 1", k, ram_reb[k]); end
            checks++;
            if (used[k] !== 4'd0) begin errors++; $display("FAIL rst%0d_used: got %0d expected 0", k, used[k]); end
            checks++;
            if (wr_ready[k] !== 1'b0) begin errors++; $display("FAIL rst%0d_wr_ready: got %b expected 0", k, wr_ready[k]); end
        end
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_valid[k] = 1'b0;
            rd_ready[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd_valid[k] !== 1'b0 || ram_web[k] !== 1'b1 || ram_reb[k] !== 1'b1 || used[k] !== 4'd0)
            begin
                errors++;
                $display("FAIL post_rst%0d: got valid=%b web=%b reb=%b used=%0d expected 0 1 1 0",
                         k, rd_valid[k], ram_web[k], ram_reb[k], used[k]);
            end
            checks++;
            if (wr_ready[k] !== 1'b1) begin errors++; $display("FAIL post_rst%0d_wr_ready: got %b expected 1", k, wr_ready[k]); end
        end
    endtask

    //-------------------------------------------------------------------------
    // One word through an empty L=1 FIFO: visible in cycle L+2 = 3.
    //-------------------------------------------------------------------------
    task automatic test_single();
        next_cycle();                                   // cycle 0
        wr_valid[0] = 1'b1;
        wr_data[0]  = 16'h00A5;
        rd_ready[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_web[0] !== 1'b0 || ram_wa[0] !== 3'd0 || ram_din[0] !== 16'h00A5) begin
            errors++;
            $display("FAIL single_write: got web=%b wa=%0d din=%h expected 0 0 00a5", ram_web[0], ram_wa[0], ram_din[0]);
        end
        next_cycle();                                   // cycle 1
        wr_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_reb[0] !== 1'b0 || ram_ra[0] !== 3'd0) begin
            errors++;
            $display("FAIL single_issue: got reb=%b ra=%0d expected 0 0", ram_reb[0], ram_ra[0]);
        end
        checks++;
        if (used[0] !== 4'd1 || rd_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_c1: got used=%0d valid=%b expected 1 0", used[0], rd_valid[0]);
        end
        next_cycle();                                   // cycle 2
        @(negedge clk);
        checks++;
        if (rd_valid[0] !== 1'b0 || ram_reb[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_c2: got valid=%b reb=%b expected 0 1", rd_valid[0], ram_reb[0]);
        end
        next_cycle();                                   // cycle 3
        rd_ready[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 16'h00A5) begin
            errors++;
            $display("FAIL single_out: got valid=%b data=%h expected 1 00a5", rd_valid[0], rd_data[0]);
        end
        next_cycle();                                   // cycle 4
        rd_ready[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_valid[0] !== 1'b0 || used[0] !== 4'd0) begin
            errors++;
            $display("FAIL single_after_pop: got valid=%b used=%0d expected 0 0", rd_valid[0], used[0]);
        end
    endtask

    //-------------------------------------------------------------------------
    // Continuous streaming: in order, no gaps after the first word.
    //-------------------------------------------------------------------------
    task automatic test_stream(input int k, input int n, input int max_used);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int gaps = 0;
        int peak = 0;
        bit started = 1'b0;
        rd_ready[k] = 1'b1;
        while (got < n && cyc < n + 200) begin
            next_cycle();
            wr_valid[k] = (sent < n);
            wr_data[k]  = W'(sent);
            @(negedge clk);
            if (int'(used[k]) > peak) peak = int'(used[k]);
            if (wr_valid[k] && wr_ready[k]) sent++;
            if (rd_valid[k] && rd_ready[k]) begin
                checks++;
                if (rd_data[k] !== W'(got)) begin
                    errors++;
                    if (errors <= 20) $display("FAIL stream%0d_order: got %h expected %h", k, rd_data[k], W'(got));
                end
                got++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            cyc++;
        end
        next_cycle();
        wr_valid[k] = 1'b0;
        rd_ready[k] = 1'b0;
        checks++;
        if (got !== n) begin errors++; $display("FAIL stream%0d_count: got %0d expected %0d", k, got, n); end
        checks++;
        if (gaps !== 0) begin errors++; $display("FAIL stream%0d_gaps: got %0d expected 0", k, gaps); end
        checks++;
        if (peak > max_used) begin errors++; $display("FAIL stream%0d_peak_used: got %0d expected <= %0d", k, peak, max_used); end
    endtask

    //-------------------------------------------------------------------------
    // Fill DEPTH=8, L=1 with the reader stalled: 8 + S = 11 words accepted.
    //-------------------------------------------------------------------------
    task automatic test_full();
        int accepted = 0;
        int popped   = 0;
        rd_ready[0] = 1'b0;
        for (int c = 0; c < 30; c++) begin
            next_cycle();
            wr_valid[0] = 1'b1;
            wr_data[0]  = W'(accepted);
            @(negedge clk);
            if (wr_ready[0]) accepted++;
        end
        next_cycle();
        wr_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (accepted !== 11) begin errors++; $display("FAIL full_accepted: got %0d expected 11", accepted); end
        checks++;
        if (used[0] !== 4'd11) begin errors++; $display("FAIL full_used: got %0d expected 11", used[0]); end
        checks++;
        if (wr_ready[0] !== 1'b0 || rd_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL full_flags: got wr_ready=%b rd_valid=%b expected 0 1", wr_ready[0], rd_valid[0]);
        end
        // Drain. First pop frees skid credit, the issue follows next cycle,
        // and wr_ready rises the cycle after that.
        next_cycle();
        rd_ready[0] = 1'b1;
        for (int d = 0; d < 40 && popped < 11; d++) begin
            if (d > 0) next_cycle();
            @(negedge clk);
            if (d < 2) begin
                checks++;
                if (wr_ready[0] !== 1'b0) begin errors++; $display("FAIL full_wr_ready_d%0d: got 1 expected 0", d); end
            end else if (d == 2) begin
                checks++;
                if (wr_ready[0] !== 1'b1) begin errors++; $display("FAIL full_wr_ready_rise: got 0 expected 1"); end
            end
            if (rd_valid[0]) begin
                checks++;
                if (rd_data[0] !== W'(popped)) begin
                    errors++;
                    $display("FAIL full_drain_order: got %h expected %h", rd_data[0], W'(popped));
                end
                popped++;
            end
        end
        next_cycle();
        rd_ready[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (popped !== 11 || used[0] !== 4'd0) begin
            errors++;
            $display("FAIL full_drained: got popped=%0d used=%0d expected 11 0", popped, used[0]);
        end
    endtask

    //-------------------------------------------------------------------------
    // Random traffic on DEPTH=5, L=3 with phases that reach full and empty.
    //-------------------------------------------------------------------------
    task automatic test_wrap();
        int p_wr [5] = '{70, 30, 50, 95, 15};
        int p_rd [5] = '{30, 70, 50, 20, 90};
        int bad_addr = 0;
        int bad_hold = 0;
        int bad_used = 0;
        int full_seen = 0;
        int wait_cyc = 0;
        bit stalled = 1'b0;
        logic [W-1:0] held_d = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            next_cycle();
            wr_valid[1] = ($urandom_range(0, 99) < p_wr[cyc / 2000]);
            wr_data[1]  = W'($urandom);
            rd_ready[1] = ($urandom_range(0, 99) < p_rd[cyc / 2000]);
            @(negedge clk);
            if ((!ram_web[1] && ram_wa[1] > 3'd4) || (!ram_reb[1] && ram_ra[1] > 3'd4)) bad_addr++;
            if (stalled && (rd_valid[1] !== 1'b1 || rd_data[1] !== held_d)) bad_hold++;
            if (int'(used[1]) > 10) bad_used++;
            if (!wr_ready[1]) full_seen++;
            stalled = rd_valid[1] && !rd_ready[1];
            held_d  = rd_data[1];
        end
        checks++;
        if (bad_addr !== 0) begin errors++; $display("FAIL wrap_addr_range: got %0d bad cycles expected 0", bad_addr); end
        checks++;
        if (bad_hold !== 0) begin errors++; $display("FAIL wrap_rd_data_hold: got %0d bad cycles expected 0", bad_hold); end
        checks++;
        if (bad_used !== 0) begin errors++; $display("FAIL wrap_used_max: got %0d bad cycles expected 0", bad_used); end
        checks++;
        if (full_seen == 0) begin errors++; $display("FAIL wrap_full_reached: got 0 full cycles expected > 0"); end
        // Drain everything the model still holds.
        next_cycle();
        wr_valid[1] = 1'b0;
        rd_ready[1] = 1'b1;
        while (g_sb[1].q.size() != 0 && wait_cyc < 100) begin
            @(negedge clk);
            next_cycle();
            wait_cyc++;
        end
        rd_ready[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (used[1] !== 4'd0 || rd_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain: got used=%0d valid=%b expected 0 0", used[1], rd_valid[1]);
        end
    endtask

    //-------------------------------------------------------------------------
    // Reset with 3 words in flight and 2 in the skid buffer (L=3, S=5).
    //-------------------------------------------------------------------------
    task automatic test_reset_mid();
        int wait_cyc = 0;
        rd_ready[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            wr_valid[1] = 1'b1;
            wr_data[1]  = W'(16'h0100 + c);
            @(negedge clk);
        end
        next_cycle();                                   // cycle 6
        checks++;
        if (rd_valid[1] !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", rd_valid[1]); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rd_valid[1] !== 1'b0 || used[1] !== 4'd0) begin
            errors++;
            $display("FAIL mid_async_clear: got valid=%b used=%0d expected 0 0", rd_valid[1], used[1]);
        end
        checks++;
        if (ram_web[1] !== 1'b1 || ram_reb[1] !== 1'b1 || wr_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_ram: got web=%b reb=%b wr_ready=%b expected 1 1 0",
                     ram_web[1], ram_reb[1], wr_ready[1]);
        end
        wr_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (rd_valid[1] !== 1'b0) begin errors++; $display("FAIL mid_stale_return_c%0d: got 1 expected 0", c); end
            next_cycle();
        end
        wr_valid[1] = 1'b1;
        wr_data[1]  = 16'h003C;
        next_cycle();
        wr_valid[1] = 1'b0;
        @(negedge clk);
        while (!rd_valid[1] && wait_cyc < 20) begin
            next_cycle();
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (rd_valid[1] !== 1'b1 || rd_data[1] !== 16'h003C) begin
            errors++;
            $display("FAIL mid_first_after_rst: got valid=%b data=%h expected 1 003c", rd_valid[1], rd_data[1]);
        end
        next_cycle();
        rd_ready[1] = 1'b1;
        next_cycle();
        rd_ready[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_valid[1] !== 1'b0 || used[1] !== 4'd0) begin
            errors++;
            $display("FAIL mid_final_empty: got valid=%b used=%0d expected 0 0", rd_valid[1], used[1]);
        end
    endtask

    //-------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wr_valid[k] = 1'b0;
            wr_data[k]  = '0;
            rd_ready[k] = 1'b0;
        end
        test_reset();
        test_single();
        test_stream(0, 1000, 4);
        test_stream(1, 1000, 6);
        test_full();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
